// File: rtl/rv_pkg.sv
// Shared RISC-V front-end definitions.
// Contents:
//   XLEN           machine word width (32)
//   OPC_*          7-bit major opcodes used by fetch-side predecode
//   fetch_entry_t  65-bit FIFO payload {pred, pc, insn}
//   b_imm()        sign-extended B-type branch offset of an instruction word
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic            pred;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] insn;
    } fetch_entry_t;

    // Scattered B-type immediate: {imm[12], imm[11], imm[10:5], imm[4:1], 0}.
    function automatic logic [XLEN-1:0] b_imm(input logic [XLEN-1:0] insn);
        return {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of the fetch unit's memory-side and decode-side signals.
// Memory side : imem_req, imem_addr (fetch -> memory), imem_rdata (memory -> fetch)
// Control     : redirect, redirect_pc (backend -> fetch)
// Decode side : instr, instr_pc, instr_valid, pred_taken (fetch -> decode),
//               instr_ready (decode -> fetch)
// modport master is the fetch unit; modport slave is everything around it.
interface instr_fetch_if;
    import rv_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic            pred_taken;

    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_valid, pred_taken,
        input  imem_rdata, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_valid, pred_taken,
        output imem_rdata, redirect, redirect_pc, instr_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched words with single-cycle flush.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   flush      empties the FIFO; a pop in the same cycle is ignored
//   push       write push_data (caller guarantees space)
//   push_data  65-bit entry {pred, pc, insn}
//   pop        remove head (ignored when empty)
//   head       entry at the read pointer
//   count      number of valid entries, 0..DEPTH
module fetch_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop = pop && (count != '0) && !flush;
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= bump(wr_ptr);
            if (do_pop) rd_ptr <= bump(rd_ptr);
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; entries are only observed while count != 0.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: holds the PC, issues sequential requests to a
// 1-cycle-latency instruction memory, buffers returned words with their PC and
// hands them to decode over valid/ready. A redirect flushes everything.
// Optional build macro STATIC_BTFN_EN: predecode backward conditional branches
// as taken, steer the PC to the branch target and drop the wrong-path fetch.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        instr_fetch_if.master (imem_*, redirect*, instr*, pred_taken)
module instr_fetch
    import rv_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_fetch_if.master        bus
);

    localparam int               CNT_W    = $clog2(DEPTH+1);
    localparam logic [CNT_W:0]   FULL_LVL = DEPTH[CNT_W:0];

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight_v;
    logic            issue;
    logic            push;
    logic            pred_bit;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]  occupancy;
    fetch_entry_t    push_data;
    fetch_entry_t    head;
    logic            unused_rpc;

    // Same-cycle pop is not credited, so a request always has a free slot.
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight_v};
    assign issue     = !rst && !bus.redirect && (occupancy < FULL_LVL);

`ifdef STATIC_BTFN_EN
    logic squash;
    logic predict;

    assign predict  = (bus.imem_rdata[6:0] == OPC_BRANCH) && bus.imem_rdata[31];
    assign push     = inflight_v && !squash && !rst && !bus.redirect;
    assign pred_bit = predict;
    assign bus.pred_taken = bus.instr_valid && head.pred;

    // The request issued alongside a predicted-taken push is wrong-path.
    always_ff @(posedge clk) begin
        if (rst || bus.redirect) squash <= 1'b0;
        else                     squash <= issue && push && predict;
    end

    always_comb begin
        pc_next = issue ? pc + 32'd4 : pc;
        if (push && predict) pc_next = inflight_pc + b_imm(bus.imem_rdata);
    end
`else
    logic unused_pred;

    assign push     = inflight_v && !rst && !bus.redirect;
    assign pred_bit = 1'b0;
    assign bus.pred_taken = 1'b0;
    assign unused_pred    = head.pred;

    always_comb begin
        pc_next = issue ? pc + 32'd4 : pc;
    end
`endif

    assign push_data = '{pred: pred_bit, pc: inflight_pc, insn: bus.imem_rdata};
    assign unused_rpc = ^bus.redirect_pc[1:0];

    // Request stage: PC and the single outstanding memory access.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            inflight_v <= 1'b0;
        end else if (bus.redirect) begin
            pc         <= {bus.redirect_pc[XLEN-1:2], 2'b00};
            inflight_v <= 1'b0;
        end else begin
            pc         <= pc_next;
            inflight_v <= issue;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) inflight_pc <= pc;
    end

    // Response stage: returned word joins the decode buffer.
    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect),
        .push      (push),
        .push_data (push_data),
        .pop       (bus.instr_valid && bus.instr_ready),
        .head      (head),
        .count     (count)
    );

    assign bus.imem_req    = issue;
    assign bus.imem_addr   = pc;
    assign bus.instr_valid = (count != '0) && !rst;
    assign bus.instr       = head.insn;
    assign bus.instr_pc    = head.pc;

endmodule
